spi_flash_xip: RTL and testbench
================================

SPI_FLASH_XIP -- requirements
Module: spi_flash_xip

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: spi_clk period = 2*CLK_DIV sys_clk cycles; legal range 1..255.
REQ-002 SHALL provide parameter ADDR_BITS, default 24: flash address width sent on the bus; legal values 24 or 32.
REQ-003 SHALL provide parameter READ_CMD, default 8'h03: opcode used for reads.
REQ-004 SHALL provide parameter HOLD_MAX, default 16: sys_clk cycles CS stays low awaiting a sequential read.
REQ-005 SHALL provide port sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL provide port sys_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL provide ports adr_i in 32 / dat_i in 32 / dat_o out 32 / sel_i in 4 (ignored) / stb_i in 1 / cyc_i in 1 / we_i in 1 / ack_o out 1: Wishbone classic slave.
REQ-008 SHALL provide ports spi_cs_n out 1 / spi_clk out 1 / spi_mosi out 1 / spi_miso in 1: SPI mode 0 master.

Function
REQ-009 SHALL start a transaction when stb_i&cyc_i are high in IDLE or HOLD; inputs sampled that cycle.
REQ-010 SHALL drive spi_clk low when idle; MOSI changes on spi_clk falling edge (first bit before first rise); MISO sampled on rising edge; MSB first per byte.
REQ-011 SHALL, for read (we_i=0), use flash address A = {adr_i[ADDR_BITS-1:2], 2'b00}.
REQ-012 SHALL, for a read in HOLD with A == next_addr, skip opcode/address and shift 32 data bits with CS held low (burst continuation).
REQ-013 SHALL, otherwise, raise spi_cs_n for at least 2*CLK_DIV sys_clk cycles (if low), then lower it, send READ_CMD (8 bits), A (ADDR_BITS bits), then shift 32 data bits.
REQ-014 SHALL assemble read data little-endian: first received byte -> dat_o[7:0], fourth -> dat_o[31:24].
REQ-015 SHALL, after a read, set next_addr = A+4 (wraps modulo 2^ADDR_BITS), keep spi_cs_n low and enter HOLD.
REQ-016 SHALL leave HOLD (spi_cs_n=1, IDLE) after HOLD_MAX consecutive sys_clk cycles without a request.
REQ-017 SHALL, for write (we_i=1), deselect first if in HOLD, then send opcode dat_i[31:24] followed by N = adr_i[3:2] bytes taken MSB-first from dat_i[23:0] (N=0: opcode only; N=3: all 24 bits), then raise spi_cs_n and return to IDLE.
REQ-018 SHALL pulse ack_o high for exactly one sys_clk cycle when the last data bit has been sampled (read) or shifted out with CS raised (write); dat_o valid in the ack cycle and held until next read completes.
REQ-019 SHALL, if stb_i or cyc_i drop mid-transfer, finish the SPI transfer, suppress ack_o, raise spi_cs_n and go IDLE (no HOLD).
REQ-020 SHALL not accept a new request in the cycle ack_o is high.
REQ-021 SHALL use FSM states IDLE, DESEL, CMD, ADDR, DATA, ACK, HOLD; DESEL->CMD, CMD->ADDR (read or N>0) else ->ACK, ADDR->DATA (read) or ->ACK, DATA->ACK, ACK->HOLD (read) / IDLE (write or abort).
REQ-022 SHALL keep spi_cs_n high at least 2*CLK_DIV sys_clk cycles between any two non-continued transactions.

Reset
REQ-023 SHALL, on sys_rst high, immediately force spi_cs_n=1, spi_clk=0, spi_mosi=0, ack_o=0, dat_o=0, state IDLE, next_addr invalid; mid-transfer reset aborts without ack.
REQ-024 SHALL resume normal operation on the first sys_clk rising edge after sys_rst falls.

Verification
REQ-025 Fresh read, CLK_DIV=2, flash word 0x100 = bytes 01 02 03 04 -> CS falls, 03 00 01 00 on MOSI, dat_o=0x04030201, one-cycle ack, CS low afterwards.
REQ-026 Read 0x100 then 0x104 within 16 cycles -> no CS rise, no opcode/address, exactly 32 spi_clk edges pairs, dat_o = bytes 05..08.
REQ-027 Read 0x100 then 0x200 -> CS high >=4 sys_clk cycles, new 03 00 02 00 header.
REQ-028 Read then 20 idle cycles -> spi_cs_n rises after cycle 16; next read 0x104 sends full header.
REQ-029 Write adr_i[3:2]=0, dat_i=0x06000000 -> 8 spi_clk pulses, MOSI 0x06, CS raised, ack; adr_i[3:2]=3, dat_i=0x02000100 -> 32 bits 02 00 01 00.
REQ-030 Assert sys_rst during ADDR phase -> spi_cs_n=1, spi_clk=0 same cycle, no ack; subsequent read at 0x100 returns 0x04030201.

Source files
------------

// File: rtl/spi_flash_xip.sv
// Wishbone classic slave that reads and writes a SPI NOR flash (mode 0).
// Sequential reads keep CS low and continue the burst without a new header.
module spi_flash_xip #(
    parameter int         CLK_DIV   = 2,
    parameter int         ADDR_BITS = 24,
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter int         HOLD_MAX  = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DESEL = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_ADDR  = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
    localparam logic [2:0] S_HOLD  = 3'd6;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [8:0]  GAP_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
    localparam logic [5:0]  ABITS     = 6'(ADDR_BITS);

    logic [2:0]           state;
    logic [7:0]           div_cnt;
    logic [5:0]           bits_left;
    logic [31:0]          tx_sr;
    logic [31:0]          rx_sr;
    logic [7:0]           cmd_byte;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS-1:0] next_addr;
    logic [23:0]          wr_data;
    logic [1:0]           nbytes;
    logic                 rd;
    logic                 abort;
    logic [8:0]           cs_hi_cnt;
    logic [15:0]          hold_cnt;

    logic                 req;
    logic                 shifting;
    logic                 tick;
    logic                 rise;
    logic                 fall;
    logic                 last;
    logic                 done;
    logic                 good;
    logic                 cont;
    logic [ADDR_BITS-1:0] req_addr;
    logic [31:0]          addr_word;
    logic                 unused_bits;

    assign req      = stb_i & cyc_i;
    assign req_addr = {adr_i[ADDR_BITS-1:2], 2'b00};
    assign shifting = (state == S_CMD) || (state == S_ADDR)
                   || (state == S_DATA);
    assign tick     = shifting && (div_cnt == DIV_LAST);
    assign rise     = tick && !spi_clk;
    assign fall     = tick && spi_clk;
    assign last     = fall && (bits_left == 6'd1);
    assign good     = !abort && req;
    assign cont     = (state == S_HOLD) && req && !we_i
                   && (req_addr == next_addr);
    assign done     = last && ((state == S_DATA)
                   || (state == S_ADDR && !rd)
                   || (state == S_CMD && !rd && nbytes == 2'd0));
    // The second phase carries the address for reads, payload for writes.
    assign addr_word = rd ? (32'(addr) << (32 - ADDR_BITS))
                          : {wr_data, 8'h00};
    assign unused_bits = ^{sel_i, adr_i};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bits_left <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            cmd_byte  <= '0;
            addr      <= '0;
            next_addr <= '0;
            wr_data   <= '0;
            nbytes    <= '0;
            rd        <= 1'b0;
            abort     <= 1'b0;
            cs_hi_cnt <= '0;
            hold_cnt  <= '0;
            dat_o     <= '0;
            ack_o     <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            ack_o   <= 1'b0;
            div_cnt <= (shifting && !tick) ? div_cnt + 8'd1 : '0;
            if (!spi_cs_n)
                cs_hi_cnt <= '0;
            else if (cs_hi_cnt != 9'h1ff)
                cs_hi_cnt <= cs_hi_cnt + 9'd1;
            if (shifting) begin
                if (tick)
                    spi_clk <= !spi_clk;
                if (rise)
                    rx_sr <= {rx_sr[30:0], spi_miso};
                if (fall && bits_left != 6'd1) begin
                    tx_sr     <= tx_sr << 1;
                    spi_mosi  <= tx_sr[30];
                    bits_left <= bits_left - 6'd1;
                end
                if (!req)
                    abort <= 1'b1;
            end
            unique case (state)
                S_IDLE, S_HOLD: begin
                    if (req) begin
                        rd       <= !we_i;
                        addr     <= req_addr;
                        cmd_byte <= we_i ? dat_i[31:24] : READ_CMD;
                        wr_data  <= dat_i[23:0];
                        nbytes   <= adr_i[3:2];
                        abort    <= 1'b0;
                        if (cont) begin
                            state     <= S_DATA;
                            tx_sr     <= '0;
                            spi_mosi  <= 1'b0;
                            bits_left <= 6'd32;
                        end else begin
                            state <= S_DESEL;
                        end
                    end else if (state == S_HOLD) begin
                        if (hold_cnt == HOLD_LAST) begin
                            spi_cs_n <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 16'd1;
                        end
                    end
                end
                S_DESEL: begin
                    spi_cs_n <= 1'b1;
                    if (!req)
                        abort <= 1'b1;
                    if (spi_cs_n && cs_hi_cnt >= GAP_LAST) begin
                        spi_cs_n  <= 1'b0;
                        state     <= S_CMD;
                        tx_sr     <= {cmd_byte, 24'h0};
                        spi_mosi  <= cmd_byte[7];
                        bits_left <= 6'd8;
                    end
                end
                S_CMD: begin
                    if (last && !done) begin
                        state     <= S_ADDR;
                        tx_sr     <= addr_word;
                        spi_mosi  <= addr_word[31];
                        bits_left <= rd ? ABITS
                                        : {1'b0, nbytes, 3'b000};
                    end
                end
                S_ADDR: begin
                    if (last && !done) begin
                        state     <= S_DATA;
                        tx_sr     <= '0;
                        spi_mosi  <= 1'b0;
                        bits_left <= 6'd32;
                    end
                end
                S_DATA: begin
                end
                S_ACK: begin
                    hold_cnt <= '0;
                    state    <= (rd && !abort) ? S_HOLD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (done) begin
                state <= S_ACK;
                ack_o <= good;
                if (!rd || !good)
                    spi_cs_n <= 1'b1;
                if (rd && good) begin
                    dat_o <= {rx_sr[7:0], rx_sr[15:8],
                              rx_sr[23:16], rx_sr[31:24]};
                    next_addr <= addr + ADDR_BITS'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_xip.sv
// Bench for spi_flash_xip: flash model on the SPI side, scoreboard on
// the Wishbone side checking every ack against the queued expectation.
module tb_spi_flash_xip;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = 4'hf;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        we_i = 1'b0;
    logic        ack_o;
    logic        spi_cs_n;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    always #5 sys_clk = ~sys_clk;

    spi_flash_xip dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .dat_o    (dat_o),
        .sel_i    (sel_i),
        .stb_i    (stb_i),
        .cyc_i    (cyc_i),
        .we_i     (we_i),
        .ack_o    (ack_o),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act,
                        input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Flash contents: 0x100..0x107 hold 01..08, elsewhere addr^0x5A.
    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (a >= 24'h100 && a < 24'h108) return 8'(a - 24'hff);
        return a[7:0] ^ 8'h5a;
    endfunction

    logic [31:0] hdr = '0;
    logic [7:0]  bsr = '0;
    logic [7:0]  fb;
    logic [23:0] ba;
    logic        miso_next = 1'b0;
    int          fcnt = 0;
    int          bcnt = 0;
    int          k;
    int          n_rise = 0;
    logic [7:0]  mlog[$];

    always @(posedge spi_clk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            fcnt = 0;
            bcnt = 0;
        end else begin
            n_rise++;
            fcnt++;
            bsr = {bsr[6:0], spi_mosi};
            bcnt++;
            if (bcnt == 8) begin
                mlog.push_back(bsr);
                bcnt = 0;
            end
            if (fcnt <= 32) hdr = {hdr[30:0], spi_mosi};
            if (fcnt >= 32 && hdr[31:24] == 8'h03) begin
                k = fcnt - 32;
                ba = hdr[23:0] + 24'(k / 8);
                fb = fbyte(ba);
                miso_next = fb[7 - (k % 8)];
            end
        end
    end

    always @(negedge spi_clk) spi_miso = miso_next;

    int cs_rises = 0;
    int hi_cur = 0;
    int last_hi = 0;

    always @(posedge spi_cs_n) cs_rises++;

    always @(negedge sys_clk) begin
        if (spi_cs_n) begin
            hi_cur++;
        end else begin
            if (hi_cur != 0) last_hi = hi_cur;
            hi_cur = 0;
        end
    end

    typedef struct {
        string       nm;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_ack = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_ack = 1'b0;
        end else begin
            if (prev_ack) chk1("ack_pulse", ack_o, 1'b0);
            if (ack_o) begin
                if (sb.size() == 0) begin
                    chk1("unexpected_ack", ack_o, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk_dat) chk(mon_e.nm, dat_o, mon_e.dat);
                    else chk1({mon_e.nm, "_cs"}, spi_cs_n, 1'b1);
                end
            end
            prev_ack = ack_o;
        end
    end

    task automatic wb_go(input logic [31:0] a, input logic [31:0] d,
                         input logic we);
        @(negedge sys_clk);
        adr_i = a;
        dat_i = d;
        we_i  = we;
        stb_i = 1'b1;
        cyc_i = 1'b1;
    endtask

    task automatic wb_wait_ack(input string nm);
        bit got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge sys_clk);
            if (ack_o) got = 1;
        end
        stb_i = 1'b0;
        cyc_i = 1'b0;
        we_i  = 1'b0;
        if (!got) chk1({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e,
                           input string nm);
        sb.push_back('{nm: nm, chk_dat: 1'b1, dat: e});
        wb_go(a, 32'h0, 1'b0);
        wb_wait_ack(nm);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input string nm);
        sb.push_back('{nm: nm, chk_dat: 1'b0, dat: 32'h0});
        wb_go(a, d, 1'b1);
        wb_wait_ack(nm);
    endtask

    task automatic chk_hdr(input string nm, input int base,
                           input logic [31:0] e);
        logic [31:0] got = '0;
        for (int i = 0; i < 4; i++)
            got = {got[23:0],
                   (base + i < mlog.size()) ? mlog[base + i] : 8'hxx};
        chk(nm, got, e);
    endtask

    task automatic wait_rises(input int target, input string nm);
        for (int i = 0; i < 3000 && n_rise < target; i++)
            @(negedge sys_clk);
        if (n_rise < target) chk1({nm, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int lb;
    int rb;
    int cb;

    initial begin
        repeat (3) @(negedge sys_clk);
        chk1("rst_cs_n", spi_cs_n, 1'b1);
        chk1("rst_sclk", spi_clk, 1'b0);
        chk1("rst_mosi", spi_mosi, 1'b0);
        chk1("rst_ack", ack_o, 1'b0);
        chk("rst_dat", dat_o, 32'h0);
        sys_rst = 1'b0;

        lb = mlog.size();
        wb_read(32'h100, 32'h04030201, "rd_100");
        chk_hdr("hdr_100", lb, 32'h03000100);
        chk1("cs_low_after_rd", spi_cs_n, 1'b0);

        lb = mlog.size();
        rb = n_rise;
        cb = cs_rises;
        wb_read(32'h104, 32'h08070605, "rd_104_burst");
        chk("burst_edges", n_rise - rb, 32);
        chk("burst_cs_rises", cs_rises - cb, 0);
        chk_hdr("burst_no_hdr", lb, 32'h0);

        lb = mlog.size();
        wb_read(32'h200, 32'h59585b5a, "rd_200");
        chk1("cs_gap_ge4", last_hi >= 4, 1'b1);
        chk_hdr("hdr_200", lb, 32'h03000200);

        repeat (16) @(negedge sys_clk);
        chk1("hold_cs_16", spi_cs_n, 1'b0);
        @(negedge sys_clk);
        chk1("hold_cs_17", spi_cs_n, 1'b1);
        repeat (3) @(negedge sys_clk);
        lb = mlog.size();
        wb_read(32'h104, 32'h08070605, "rd_104_fresh");
        chk_hdr("hdr_104", lb, 32'h03000104);

        lb = mlog.size();
        rb = n_rise;
        wb_write(32'h0, 32'h06000000, "wr_n0");
        chk("wr_n0_edges", n_rise - rb, 8);
        chk("wr_n0_byte", {24'h0,
            (lb < mlog.size()) ? mlog[lb] : 8'hxx}, 32'h06);

        lb = mlog.size();
        rb = n_rise;
        wb_write(32'hc, 32'h02000100, "wr_n3");
        chk("wr_n3_edges", n_rise - rb, 32);
        chk_hdr("wr_n3_bytes", lb, 32'h02000100);

        rb = n_rise;
        wb_go(32'h100, 32'h0, 1'b0);
        wait_rises(rb + 12, "abort_start");
        @(negedge sys_clk);
        stb_i = 1'b0;
        cyc_i = 1'b0;
        for (int i = 0; i < 3000 && !spi_cs_n; i++)
            @(negedge sys_clk);
        chk1("abort_cs", spi_cs_n, 1'b1);
        chk("abort_edges", n_rise - rb, 64);
        repeat (20) @(negedge sys_clk);
        chk("abort_dat_held", dat_o, 32'h08070605);
        lb = mlog.size();
        wb_read(32'h104, 32'h08070605, "rd_after_abort");
        chk_hdr("hdr_after_abort", lb, 32'h03000104);

        repeat (4) @(negedge sys_clk);
        rb = n_rise;
        wb_go(32'h100, 32'h0, 1'b0);
        wait_rises(rb + 12, "rst_mid_start");
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk1("rst_mid_cs", spi_cs_n, 1'b1);
        chk1("rst_mid_sclk", spi_clk, 1'b0);
        @(negedge sys_clk);
        stb_i = 1'b0;
        cyc_i = 1'b0;
        chk1("rst_mid_ack", ack_o, 1'b0);
        chk("rst_mid_dat", dat_o, 32'h0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        lb = mlog.size();
        wb_read(32'h100, 32'h04030201, "rd_after_rst");
        chk_hdr("hdr_after_rst", lb, 32'h03000100);

        repeat (4) @(negedge sys_clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
